// File: rtl/nonce_target_checker.sv
// nonce_target_checker: scans NUM_NONCES hash result words in shared memory,
// compares each unsigned against a latched difficulty target, and reports the
// first winning nonce, the number of hits and the minimum hash with its index.
module nonce_target_checker #(
    parameter int NUM_NONCES = 16,
    parameter int IDX_W      = $clog2(NUM_NONCES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      result_addr,
    input  logic [31:0]      target,
    output logic             mem_clk,
    output logic             mem_we,
    output logic [15:0]      mem_addr,
    input  logic [31:0]      mem_read_data,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [IDX_W-1:0] win_nonce,
    output logic [IDX_W:0]   hit_count,
    output logic [31:0]      min_hash,
    output logic [IDX_W-1:0] min_nonce
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, REPORT} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] cmp_idx;
    logic             cmp_vld;
    logic [15:0]      base_q;
    logic [31:0]      target_q;
    logic             last_issue;
    logic             is_hit;
    logic             is_min;

    // memory is read-only and runs on the block clock
    assign mem_clk = clk;
    assign mem_we  = 1'b0;

    assign last_issue = (rd_idx == IDX_W'(NUM_NONCES - 1));
    assign is_hit     = (mem_read_data < target_q);
    assign is_min     = (mem_read_data < min_hash);

    // state register; reset abandons any scan in flight
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // next-state and status/address outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        mem_addr   = 16'h0000;
        case (state)
            IDLE: begin
                if (start) state_next = ISSUE;
            end
            ISSUE: begin
                busy     = 1'b1;
                mem_addr = base_q + 16'(rd_idx);  // wraps modulo 2^16
                if (last_issue) state_next = DRAIN;
            end
            DRAIN: begin
                busy       = 1'b1;
                state_next = REPORT;
            end
            REPORT: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // read index, one-cycle read-latency tag pipeline and result accumulation
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_idx    <= '0;
            cmp_vld   <= 1'b0;
            cmp_idx   <= '0;
            base_q    <= 16'h0000;
            target_q  <= 32'h0000_0000;
            found     <= 1'b0;
            win_nonce <= '0;
            hit_count <= '0;
            min_hash  <= 32'hFFFF_FFFF;
            min_nonce <= '0;
        end else begin
            // tag travels with the read so it lines up with mem_read_data
            cmp_vld <= (state == ISSUE);
            cmp_idx <= rd_idx;

            if (state == IDLE && start) begin
                base_q    <= result_addr;
                target_q  <= target;
                rd_idx    <= '0;
                found     <= 1'b0;
                win_nonce <= '0;
                hit_count <= '0;
                min_hash  <= 32'hFFFF_FFFF;
                min_nonce <= '0;
            end else if (state == ISSUE) begin
                rd_idx <= rd_idx + IDX_W'(1);
            end

            // cmp_vld is only set in ISSUE/DRAIN, never alongside a start
            if (cmp_vld) begin
                if (is_hit) begin
                    hit_count <= hit_count + {{IDX_W{1'b0}}, 1'b1};
                    if (!found) begin
                        found     <= 1'b1;
                        win_nonce <= cmp_idx;
                    end
                end
                // strict compare keeps the lowest index on ties
                if (is_min) begin
                    min_hash  <= mem_read_data;
                    min_nonce <= cmp_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_nonce_target_checker.sv
// Randomized + directed bench for nonce_target_checker with a loop-based
// reference model of the scan results and a cycle-by-cycle timing check.
module tb_nonce_target_checker;

    localparam int N  = 16;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [15:0]   result_addr;
    logic [31:0]   target;
    logic          mem_clk;
    logic          mem_we;
    logic [15:0]   mem_addr;
    logic [31:0]   mem_read_data;
    logic          busy;
    logic          done;
    logic          found;
    logic [IW-1:0] win_nonce;
    logic [IW:0]   hit_count;
    logic [31:0]   min_hash;
    logic [IW-1:0] min_nonce;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem [0:65535];
    logic [31:0] w   [N];

    nonce_target_checker #(.NUM_NONCES(N)) dut (
        .clk(clk), .reset(reset), .start(start), .result_addr(result_addr),
        .target(target), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_read_data(mem_read_data), .busy(busy), .done(done), .found(found),
        .win_nonce(win_nonce), .hit_count(hit_count), .min_hash(min_hash),
        .min_nonce(min_nonce)
    );

    always #5 clk = ~clk;

    // synchronous single-port memory: data for last cycle's address
    always @(posedge clk) mem_read_data <= mem[mem_addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'd0);
        chk({tag, ".found"}, 64'(found), 64'd0);
        chk({tag, ".win"}, 64'(win_nonce), 64'd0);
        chk({tag, ".hits"}, 64'(hit_count), 64'd0);
        chk({tag, ".min"}, 64'(min_hash), 64'hFFFF_FFFF);
        chk({tag, ".minidx"}, 64'(min_nonce), 64'd0);
        chk({tag, ".addr"}, 64'(mem_addr), 64'd0);
    endtask

    // Runs one scan of w[] placed at base. start_poke/rst_at (cycle numbers,
    // 0 = none) inject a spurious start or a reset mid-scan.
    task automatic scan(input string tag, input logic [15:0] base, input logic [31:0] tgt,
                        input int start_poke, input int rst_at);
        bit          e_found = 0;
        int          e_win   = 0;
        int          e_hits  = 0;
        logic [31:0] e_min   = 32'hFFFF_FFFF;
        int          e_mn    = 0;
        int          last;
        logic [15:0] ea;

        for (int i = 0; i < N; i++) begin
            logic [15:0] a;
            a = base + 16'(i);
            mem[a] = w[i];
            if (w[i] < tgt) begin
                e_hits++;
                if (!e_found) begin e_found = 1; e_win = i; end
            end
            if (w[i] < e_min) begin e_min = w[i]; e_mn = i; end
        end

        @(negedge clk);                       // cycle 0: start sampled at its end
        start = 1'b1; result_addr = base; target = tgt;
        last = (rst_at > 0) ? N + 4 : N + 2;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (rst_at > 0 && c > rst_at) begin
                chk_reset_vals({tag, ".post_rst"});
            end else begin
                chk({tag, ".busy"}, 64'(busy), 64'(c <= N + 1));
                chk({tag, ".done"}, 64'(done), 64'(c == N + 2));
                if (c <= N) begin
                    ea = base + 16'(c - 1);
                    chk({tag, ".addr"}, 64'(mem_addr), 64'(ea));
                end
                if (c == N + 2) begin
                    chk({tag, ".found"}, 64'(found), 64'(e_found));
                    chk({tag, ".win"}, 64'(win_nonce), 64'(e_win));
                    chk({tag, ".hits"}, 64'(hit_count), 64'(e_hits));
                    chk({tag, ".min"}, 64'(min_hash), 64'(e_min));
                    chk({tag, ".minidx"}, 64'(min_nonce), 64'(e_mn));
                end
            end
            chk({tag, ".we"}, 64'(mem_we), 64'd0);
            start = (c == start_poke);
            reset = (c == rst_at);
            if (c == 3) begin                  // latched inputs must not matter
                target      = $urandom;
                result_addr = 16'($urandom);
            end
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; result_addr = 16'h0; target = 32'h0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("idle");

        // start together with reset: reset wins
        start = 1'b1; reset = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("start_vs_reset.busy", 64'(busy), 64'd0);

        // basic scan
        for (int i = 0; i < N; i++) w[i] = 32'h8000_0000 + 32'(i);
        w[5] = 32'h0000_1234;
        w[9] = 32'h0000_0100;
        scan("basic", 16'h0100, 32'h0001_0000, 0, 0);

        // no hit, all ties for the minimum
        for (int i = 0; i < N; i++) w[i] = 32'h0000_0001;
        scan("nohit", 16'h0400, 32'h0, 0, 0);

        // equality is not a hit
        for (int i = 0; i < N; i++) w[i] = 32'hFFFF_FFFF;
        w[3] = 32'h0000_0500;
        scan("equal", 16'h0800, 32'h0000_0500, 0, 0);

        // address wrap
        for (int i = 0; i < N; i++) w[i] = $urandom;
        scan("wrap", 16'hFFFC, 32'h4000_0000, 0, 0);

        // spurious start mid-scan
        for (int i = 0; i < N; i++) w[i] = $urandom;
        scan("poke", 16'h0200, 32'h8000_0000, 5, 0);

        // reset mid-scan, then a clean scan
        for (int i = 0; i < N; i++) w[i] = $urandom >> 4;
        scan("rst", 16'h0300, 32'h0800_0000, 0, 8);
        for (int i = 0; i < N; i++) w[i] = $urandom;
        scan("after_rst", 16'h0300, 32'hC000_0000, 0, 0);

        // back-to-back: many hits, then few
        for (int i = 0; i < N; i++) w[i] = 32'(i);
        scan("b2b_a", 16'h1000, 32'h0000_000C, 0, 0);
        for (int i = 0; i < N; i++) w[i] = 32'h1000_0000 - 32'(i);
        w[2] = 32'h0000_0007;
        scan("b2b_b", 16'h2000, 32'h0000_0100, 0, 0);

        // random scans
        for (int t = 0; t < 24; t++) begin
            logic [31:0] tg;
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(3))
                    0:       w[i] = $urandom & 32'h0000_FFFF;
                    1:       w[i] = (i > 0) ? w[$urandom_range(i - 1)] : $urandom;
                    default: w[i] = $urandom;
                endcase
            end
            case ($urandom_range(2))
                0:       tg = w[$urandom_range(N - 1)];
                1:       tg = $urandom >> $urandom_range(16);
                default: tg = $urandom;
            endcase
            scan("rand", 16'($urandom), tg, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nonce_target_checker.md
Name: nonce_target_checker

Overview:
- Downstream consumer of the bitcoin hashing stage. It reads the NUM_NONCES result words (H0 of each nonce's final hash) that the hasher has written to shared memory.
- Each word is compared unsigned against a 32-bit difficulty target.
- Reports: the first winning nonce, the hit count, and the minimum hash with its nonce.
- Shares the same single-port synchronous memory interface as the hasher. Read-only; the hasher and this block never access memory in the same cycle.

Parameters:
- NUM_NONCES, 16, number of consecutive result words to scan (2..256).
- IDX_W, $clog2(NUM_NONCES), width of nonce index outputs.

Ports:
- clk  input  1  single clock; also drives mem_clk.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin scan; sampled only in IDLE.
- result_addr  input  16  base address of result word 0.
- target  input  32  difficulty threshold; latched at start.
- mem_clk  output  1  equals clk.
- mem_we  output  1  constant 0.
- mem_addr  output  16  read address.
- mem_read_data  input  32  data for the address presented in the previous cycle.
- busy  output  1  high from the cycle after start until the last compare.
- done  output  1  one-cycle pulse when results are valid.
- found  output  1  at least one word < target.
- win_nonce  output  IDX_W  lowest index with word < target; 0 if none.
- hit_count  output  IDX_W+1  number of words < target.
- min_hash  output  32  smallest word scanned.
- min_nonce  output  IDX_W  index of min_hash; lowest index on ties.

Behaviour:
- Reset (any state, highest priority): state=IDLE. Next cycle: busy=0, done=0, found=0, win_nonce=0, hit_count=0, min_hash=32'hFFFFFFFF, min_nonce=0, mem_addr=0, and internal counters cleared. An in-flight scan is abandoned and no done pulse is produced.
- States: IDLE, ISSUE, DRAIN, REPORT.
- IDLE:
  - mem_addr=0.
  - On start=1: latch result_addr and target; clear found, hit_count and win_nonce; set min_hash=FFFFFFFF and min_nonce=0; rd_idx=0; go to ISSUE.
- ISSUE:
  - mem_addr = latched result_addr + rd_idx, computed modulo 2^16 (wraps 16'hFFFF -> 16'h0000).
  - rd_idx increments each cycle.
  - After issuing index NUM_NONCES-1, go to DRAIN.
- Compare pipeline:
  - A valid flag and the index are delayed one cycle alongside the read.
  - In the cycle a word arrives (idx j):
    - if word < target (unsigned, strict): hit_count++; if found==0, set found=1 and win_nonce=j.
    - if word < min_hash (strict): min_hash=word, min_nonce=j.
  - Words equal to target are not hits.
- DRAIN: one cycle consuming the last word, then go to REPORT.
- REPORT: done=1 for exactly one cycle, then go to IDLE.
- Output hold: result outputs hold until the next accepted start.
- Timing, with start sampled at cycle 0:
  - mem_addr carries index i in cycle 1+i.
  - Word i is compared in cycle 2+i.
  - busy is high during cycles 1..NUM_NONCES+1.
  - done is high in cycle NUM_NONCES+2 (cycle 18 for the default).
- start while not IDLE: ignored. start in the same cycle as reset: reset wins.
- target=0: no hits, so found=0, hit_count=0, win_nonce=0.
- target changes mid-scan: no effect, because target is latched.
- mem_we is never asserted.

Test Plan:
- Basic scan, 16 nonces:
  - Setup: result_addr=16'h0100; words[i]=32'h8000_0000+i; word5=32'h0000_1234; word9=32'h0000_0100; target=32'h0001_0000.
  - Expect: done at cycle 18; found=1, win_nonce=5, hit_count=2, min_hash=32'h0000_0100, min_nonce=9.
- No hit:
  - Setup: target=0; all words 32'h0000_0001.
  - Expect: found=0, hit_count=0, win_nonce=0, min_hash=1, min_nonce=0 (tie keeps the lowest index).
- Equality boundary:
  - Setup: target=32'h0000_0500; word3=32'h0000_0500; all others FFFFFFFF.
  - Expect: found=0, min_hash=32'h0000_0500, min_nonce=3.
- Address wrap:
  - Setup: result_addr=16'hFFFC.
  - Expect: mem_addr sequence FFFC, FFFD, FFFE, FFFF, 0000 … 000B; results correct.
- Control robustness:
  - start pulsed at cycle 5 of a scan: ignored, single done pulse at cycle 18.
  - reset asserted at cycle 8: no done pulse, outputs at reset values, busy=0.
  - A new start after that reset completes normally.
- Back-to-back scans: a second start in the cycle after done yields fresh results, with hit_count not accumulated from the first scan.
